// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings, steering codes
// and the latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_D  = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline and memory side take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          sel;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, sel, mem_en, mem_we,
           mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, sel, mem_en, mem_we,
           mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory latency between ISSUE and RESP.
module mem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - W'(1);
  end

  // Raised when the count is spent or the pending decrement spends it.
  assign zero = (count == W'(1)) || (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and MEM-stage data access.
// Tie policy: fixed D priority by default; define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t        state, state_nxt;
  logic          grant_any, sel_nxt, tie_sel;
  logic          sel_q, we_q;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          we_nxt;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic          mem_en, busy, if_ready, d_ready;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst)                              last_grant <= SEL_D;
    else if (state == ST_IDLE && grant_any) last_grant <= sel_nxt;
  end

  assign tie_sel = (last_grant == SEL_D) ? SEL_IF : SEL_D;
`else
  // The data access belongs to the older instruction, so it always wins a tie.
  assign tie_sel = SEL_D;
`endif

  always_comb begin
    grant_any = bus.if_req | bus.d_req;
    sel_nxt   = SEL_IF;
    if (bus.if_req && bus.d_req) sel_nxt = tie_sel;
    else if (bus.d_req)          sel_nxt = SEL_D;
  end

  // Address/data steering follows the next-state select so it is ready at the grant edge.
  assign addr_nxt  = (sel_nxt == SEL_D) ? bus.d_addr  : bus.if_addr;
  assign wdata_nxt = (sel_nxt == SEL_D) ? bus.d_wdata : '0;
  assign we_nxt    = (sel_nxt == SEL_D) & bus.d_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= SEL_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == ST_IDLE && grant_any) begin
      sel_q   <= sel_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (LAT_M1 != '0) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (cnt_zero) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_ISSUE: begin
        mem_en   = 1'b1;
        cnt_load = 1'b1;
      end
      ST_WAIT:  cnt_dec = 1'b1;
      ST_RESP: begin
        if_ready = (sel_q == SEL_IF);
        d_ready  = (sel_q == SEL_D);
      end
      default: ;
    endcase
  end

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_M1),
    .zero     (cnt_zero)
  );

  assign bus.sel       = sel_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy;
  assign bus.if_ready  = if_ready;
  assign bus.d_ready   = d_ready;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three instances at MEM_LAT = 1, 3 and 4.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.AW(32), .DW(32)) i1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) i3 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) i4 ();

  mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u1 (.clk(clk), .rst(rst), .bus(i1));
  mem_port_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) u3 (.clk(clk), .rst(rst), .bus(i3));
  mem_port_arbiter #(.MEM_LAT(4), .AW(32), .DW(32)) u4 (.clk(clk), .rst(rst), .bus(i4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    i1.if_req = 1'b1; i1.d_req = 1'b1; i1.d_we = 1'b1;
    i3.if_req = 1'b1; i3.d_req = 1'b1; i3.d_we = 1'b1;
    i4.if_req = 1'b1; i4.d_req = 1'b1; i4.d_we = 1'b1;
    i1.d_addr = 32'h1234; i1.d_wdata = 32'h5555_aaaa;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({i1.mem_en, i1.sel, i1.mem_we, i1.busy, i1.if_ready, i1.d_ready,
           i3.mem_en, i3.sel, i3.mem_we, i3.busy, i3.if_ready, i3.d_ready,
           i4.mem_en, i4.sel, i4.mem_we, i4.busy, i4.if_ready, i4.d_ready} !== 18'd0) begin
        failures++;
        $display("FAIL reset_flags: cycle %0d got %b/%b/%b want all zero", c,
                 {i1.mem_en, i1.sel, i1.mem_we, i1.busy, i1.if_ready, i1.d_ready},
                 {i3.mem_en, i3.sel, i3.mem_we, i3.busy, i3.if_ready, i3.d_ready},
                 {i4.mem_en, i4.sel, i4.mem_we, i4.busy, i4.if_ready, i4.d_ready});
      end
      checks++;
      if (u1.state !== ST_IDLE || u3.state !== ST_IDLE || u4.state !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_state: got %0d/%0d/%0d want 0", u1.state, u3.state, u4.state);
      end
      checks++;
      if ({i1.mem_addr, i1.mem_wdata, i3.mem_addr, i4.mem_addr} !== 128'd0) begin
        failures++;
        $display("FAIL reset_data: addr %h wdata %h want 0", i1.mem_addr, i1.mem_wdata);
      end
    end
    i1.if_req = 1'b0; i1.d_req = 1'b0; i1.d_we = 1'b0;
    i3.if_req = 1'b0; i3.d_req = 1'b0; i3.d_we = 1'b0;
    i4.if_req = 1'b0; i4.d_req = 1'b0; i4.d_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({i1.busy, i1.mem_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release_idle: busy/mem_en %b want 00", {i1.busy, i1.mem_en});
    end
  endtask

  task automatic test_if_read;
    i1.if_addr = 32'h0000_0040; i1.mem_rdata = 32'h0051_3093; i1.if_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({i1.mem_en, i1.sel, i1.mem_we, i1.busy} !== 4'b1001 || i1.mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL if_issue: en/sel/we/busy %b addr %h want 1001 addr 00000040",
               {i1.mem_en, i1.sel, i1.mem_we, i1.busy}, i1.mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i1.if_ready, i1.d_ready, i1.mem_en} !== 3'b100) begin
      failures++;
      $display("FAIL if_ready: if/d/en %b want 100", {i1.if_ready, i1.d_ready, i1.mem_en});
    end
    checks++;
    if (i1.if_rdata !== 32'h0051_3093) begin
      failures++;
      $display("FAIL if_rdata: got %h want 00513093", i1.if_rdata);
    end
    i1.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({i1.busy, i1.if_ready, i1.mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL if_done: busy/rdy/en %b want 000", {i1.busy, i1.if_ready, i1.mem_en});
    end
  endtask

  task automatic test_d_write_lat3;
    i3.d_addr = 32'h0000_1000; i3.d_wdata = 32'hDEAD_BEEF; i3.d_we = 1'b1; i3.d_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({i3.mem_en, i3.sel, i3.mem_we, i3.busy} !== 4'b1111) begin
      failures++;
      $display("FAIL d_issue: en/sel/we/busy %b want 1111", {i3.mem_en, i3.sel, i3.mem_we, i3.busy});
    end
    checks++;
    if (i3.mem_wdata !== 32'hDEAD_BEEF || i3.mem_addr !== 32'h1000) begin
      failures++;
      $display("FAIL d_issue_data: addr %h wdata %h want 00001000 deadbeef", i3.mem_addr, i3.mem_wdata);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({i3.mem_en, i3.busy, i3.d_ready, i3.if_ready} !== {1'b0, 1'b1, (k == 4), 1'b0}) begin
        failures++;
        $display("FAIL d_wait_t%0d: en/busy/drdy/irdy %b want %b", k,
                 {i3.mem_en, i3.busy, i3.d_ready, i3.if_ready}, {1'b0, 1'b1, (k == 4), 1'b0});
      end
      checks++;
      if (i3.sel !== 1'b1 || i3.mem_addr !== 32'h1000) begin
        failures++;
        $display("FAIL d_hold_t%0d: sel %b addr %h want 1 00001000", k, i3.sel, i3.mem_addr);
      end
    end
    i3.d_req = 1'b0; i3.d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({i3.busy, i3.d_ready, i3.mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL d_done: busy/rdy/en %b want 000", {i3.busy, i3.d_ready, i3.mem_en});
    end
  endtask

`ifndef MEM_ARB_RR_EN
  task automatic test_tie_fixed;
    for (int rep = 0; rep < 3; rep++) begin
      i1.if_addr = 32'h0000_0040; i1.d_addr = 32'h0000_2000; i1.d_we = 1'b0;
      i1.if_req = 1'b1; i1.d_req = 1'b1;
      @(negedge clk);
      checks++;
      if ({i1.mem_en, i1.sel} !== 2'b11 || i1.mem_addr !== 32'h2000) begin
        failures++;
        $display("FAIL tie%0d_d_first: en/sel %b addr %h want 11 00002000", rep,
                 {i1.mem_en, i1.sel}, i1.mem_addr);
      end
      @(negedge clk);
      checks++;
      if ({i1.d_ready, i1.if_ready} !== 2'b10) begin
        failures++;
        $display("FAIL tie%0d_d_ready: d/if %b want 10", rep, {i1.d_ready, i1.if_ready});
      end
      i1.d_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({i1.busy, i1.mem_en} !== 2'b00) begin
        failures++;
        $display("FAIL tie%0d_idle: busy/en %b want 00", rep, {i1.busy, i1.mem_en});
      end
      @(negedge clk);
      checks++;
      if ({i1.mem_en, i1.sel, i1.mem_we} !== 3'b100 || i1.mem_addr !== 32'h40) begin
        failures++;
        $display("FAIL tie%0d_if_issue: en/sel/we %b addr %h want 100 00000040", rep,
                 {i1.mem_en, i1.sel, i1.mem_we}, i1.mem_addr);
      end
      @(negedge clk);
      checks++;
      if ({i1.if_ready, i1.d_ready} !== 2'b10) begin
        failures++;
        $display("FAIL tie%0d_if_ready: if/d %b want 10", rep, {i1.if_ready, i1.d_ready});
      end
      i1.if_req = 1'b0;
      @(negedge clk);
    end
  endtask
`else
  task automatic test_tie_round_robin;
    bit found;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i1.if_addr = 32'h0000_0040; i1.d_addr = 32'h0000_2000; i1.d_we = 1'b0;
    i1.if_req = 1'b1; i1.d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
        @(negedge clk);
        if (i1.mem_en === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL rr%0d_grant: no mem_en within 4 cycles", g);
      end
      checks++;
      if (i1.sel !== g[0] || i1.mem_addr !== (g[0] ? 32'h2000 : 32'h40)) begin
        failures++;
        $display("FAIL rr%0d_order: sel %b addr %h want sel %b", g, i1.sel, i1.mem_addr, g[0]);
      end
      @(negedge clk);
      checks++;
      if ({i1.if_ready, i1.d_ready} !== (g[0] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr%0d_ready: if/d %b want %b", g, {i1.if_ready, i1.d_ready},
                 (g[0] ? 2'b01 : 2'b10));
      end
    end
    i1.if_req = 1'b0; i1.d_req = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_in_wait;
    int ens, rdys, first_rdy;
    i4.d_addr = 32'h0000_3000; i4.d_we = 1'b0; i4.mem_rdata = 32'h1234_5678; i4.d_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({i4.mem_en, i4.sel} !== 2'b11) begin
      failures++;
      $display("FAIL abort_issue: en/sel %b want 11", {i4.mem_en, i4.sel});
    end
    @(negedge clk);
    checks++;
    if ({i4.mem_en, i4.busy, i4.d_ready} !== 3'b010 || u4.state !== ST_WAIT) begin
      failures++;
      $display("FAIL abort_wait: en/busy/rdy %b state %0d want 010 state 2",
               {i4.mem_en, i4.busy, i4.d_ready}, u4.state);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({i4.busy, i4.d_ready, i4.mem_en} !== 3'b000 || u4.state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_idle: busy/rdy/en %b state %0d want 000 state 0",
               {i4.busy, i4.d_ready, i4.mem_en}, u4.state);
    end
    rst = 1'b0;
    ens = 0; rdys = 0; first_rdy = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i4.mem_en === 1'b1) ens++;
      if (i4.d_ready === 1'b1) begin
        rdys++;
        if (first_rdy < 0) first_rdy = c;
        checks++;
        if (i4.d_rdata !== 32'h1234_5678) begin
          failures++;
          $display("FAIL reissue_rdata: got %h want 12345678", i4.d_rdata);
        end
        i4.d_req = 1'b0;
      end
    end
    checks++;
    if (ens != 1) begin
      failures++;
      $display("FAIL reissue_mem_en: count %0d want 1", ens);
    end
    checks++;
    if (rdys != 1 || first_rdy != 4) begin
      failures++;
      $display("FAIL reissue_ready: count %0d at %0d want 1 at 4", rdys, first_rdy);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    i1.if_req = 1'b0; i1.if_addr = '0; i1.d_req = 1'b0; i1.d_we = 1'b0;
    i1.d_addr = '0; i1.d_wdata = '0; i1.mem_rdata = '0;
    i3.if_req = 1'b0; i3.if_addr = '0; i3.d_req = 1'b0; i3.d_we = 1'b0;
    i3.d_addr = '0; i3.d_wdata = '0; i3.mem_rdata = '0;
    i4.if_req = 1'b0; i4.if_addr = '0; i4.d_req = 1'b0; i4.d_we = 1'b0;
    i4.d_addr = '0; i4.d_wdata = '0; i4.mem_rdata = '0;
    test_reset();
    test_if_read();
    test_d_write_lat3();
`ifndef MEM_ARB_RR_EN
    test_tie_fixed();
`else
    test_tie_round_robin();
`endif
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
